pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch front end for the MIPS pipeline: owns the program counter, issues word fetches to instruction memory over a request/response handshake, and delivers fetched instructions with their PC to the IF/ID stage. It is the consumer of the PC+4 increment path and the producer of the instruction stream. It supports decode stalls and branch/jump redirects.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Stall  in  1  downstream (IF/ID) cannot accept an instruction this cycle
- Redirect_Valid  in  1  branch/jump taken; load Redirect_PC
- Redirect_PC  in  32  redirect target
- IMem_Req  out  1  fetch request valid
- IMem_Addr  out  32  fetch word address
- IMem_Ready  in  1  memory accepts request (handshake = IMem_Req & IMem_Ready)
- IMem_RValid  in  1  read data valid, exactly one per accepted request, ≥1 cycle after acceptance
- IMem_RData  in  32  instruction word
- Inst_Valid  out  1  Inst/Inst_PC hold a valid instruction
- Inst  out  32  fetched instruction
- Inst_PC  out  32  address of Inst
- PC_Result  out  32  current fetch PC

## Operation
- States: REQ (request may issue), WAIT (one request outstanding), DRAIN (outstanding response to be discarded).
- Reset: state REQ, PC=RESET_PC, Inst_Valid=0, Inst=0, Inst_PC=0, skid buffer empty, IMem_Req=0 during reset.
- IMem_Req = (state==REQ) & !skid_full & !(Inst_Valid & Stall); IMem_Addr = PC; PC_Result = PC.
- REQ: on handshake, latch Req_PC=PC, PC <= PC+4 (32-bit, wraps 32'hFFFFFFFC→0), go WAIT.
- WAIT: on IMem_RValid, if output register free or being consumed (!Inst_Valid | !Stall) load Inst/Inst_PC=Req_PC, Inst_Valid=1; else write skid buffer. Go REQ.
- Output consume: Inst_Valid & !Stall. If skid full, skid moves to output next cycle; else Inst_Valid clears unless a new response loads.
- Redirect (highest priority, any state): PC <= Redirect_PC; Inst_Valid <= 0; skid cleared. From WAIT without same-cycle RValid, or from REQ with same-cycle handshake → DRAIN. From WAIT with same-cycle RValid → response discarded, go REQ. Otherwise → REQ.
- DRAIN: IMem_Req=0; on IMem_RValid discard data, go REQ. Redirect in DRAIN updates PC, stays DRAIN.
- At most one request outstanding; skid depth 1 guarantees no response is lost.

## Timing
- Fetch latency: handshake in cycle N, RValid in cycle N+k → Inst_Valid high in N+k+1.
- Back-to-back with k=1, Ready=1, no stall: one instruction every 2 cycles.
- Redirect asserted cycle N: IMem_Addr=Redirect_PC at N+1 (if not DRAIN); Inst_Valid low at N+1.
- rst_n assertion mid-operation: all state to reset values immediately; in-flight response after reset is ignored only by memory reset (memory shares rst_n).

## Configuration
- PC_ALIGN_CHECK_EN defined: extra output Fetch_Misalign (1 bit, reset 0). Redirect_PC[1:0]!=0 sets Fetch_Misalign=1 sticky until reset or an aligned redirect; IMem_Req held 0 while set.
- Undefined: no port, Redirect_PC[1:0] forced to 2'b00 when loaded.

## Structure
- Shared package mips_pkg: fetch state enum (REQ/WAIT/DRAIN), PC_INC constant 32'd4, RESET_PC default.
- One sub-module: pc_incr (combinational PC+PC_INC); FSM, PC register, skid buffer in pc_fetch.

## Test plan
- Reset release, Ready=1, memory k=1 returning 32'h20080001 at 0 → IMem_Addr 0 then 4; Inst_Valid with Inst=32'h20080001, Inst_PC=0.
- Stall held 5 cycles with Inst_Valid=1 → Inst/Inst_PC stable, one response captured in skid, no further IMem_Req; release → skid instruction delivered next cycle.
- Redirect to 32'h00400100 while WAIT (k=3) → old response discarded (never on Inst), next IMem_Addr=32'h00400100.
- Redirect same cycle as RValid → response dropped, Inst_Valid=0, request at target next cycle.
- PC=32'hFFFFFFFC fetch → next IMem_Addr=0.
- PC_ALIGN_CHECK_EN: Redirect_PC=32'h00000102 → Fetch_Misalign=1, IMem_Req=0; redirect to 32'h00000100 → clears, fetch resumes.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants.
// Fetch FSM states, PC increment and reset PC default.
package mips_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_incr.sv
// Combinational PC incrementer for the fetch front end.
// Wraps naturally at 32 bits (32'hFFFFFFFC -> 0).
module pc_incr
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] pc_next
);

    assign pc_next = pc + PC_INC;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch front end: PC, one-outstanding imem handshake, skid.
// Optional PC_ALIGN_CHECK_EN adds the sticky Fetch_Misalign output.
module pc_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_PC,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ready,
    input  logic        IMem_RValid,
    input  logic [31:0] IMem_RData,
    output logic        Inst_Valid,
    output logic [31:0] Inst,
    output logic [31:0] Inst_PC,
`ifdef PC_ALIGN_CHECK_EN
    output logic        Fetch_Misalign,
`endif
    output logic [31:0] PC_Result
);

    fetch_state_t state;
    fetch_state_t state_nx;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] req_pc;
    logic [31:0] redir_pc;
    logic        misalign;

    logic        skid_full;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;

    logic        hs;
    logic        resp;
    logic        consume;
    logic        out_free;

    pc_incr u_incr (
        .pc      (pc),
        .pc_next (pc_plus4)
    );

`ifdef PC_ALIGN_CHECK_EN
    assign redir_pc = Redirect_PC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else if (Redirect_Valid) begin
            misalign <= |Redirect_PC[1:0];
        end
    end

    assign Fetch_Misalign = misalign;
`else
    assign redir_pc = Redirect_PC & ~32'd3;
    assign misalign = 1'b0;
`endif

    // Request is also gated by rst_n so nothing issues while held in reset.
    assign IMem_Req = rst_n & (state == REQ) & ~skid_full
                    & ~(Inst_Valid & Stall) & ~misalign;
    assign IMem_Addr = pc;
    assign PC_Result = pc;

    assign hs       = IMem_Req & IMem_Ready;
    assign resp     = (state == WAIT) & IMem_RValid;
    assign consume  = Inst_Valid & ~Stall;
    assign out_free = ~Inst_Valid | ~Stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            REQ:     if (hs) state_nx = WAIT;
            WAIT:    if (IMem_RValid) state_nx = REQ;
            DRAIN:   if (IMem_RValid) state_nx = REQ;
            default: state_nx = REQ;
        endcase
        // A response still owed after a redirect must be swallowed.
        if (Redirect_Valid) begin
            if (hs) begin
                state_nx = DRAIN;
            end else if ((state != REQ) && !IMem_RValid) begin
                state_nx = DRAIN;
            end else begin
                state_nx = REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            req_pc <= 32'd0;
        end else if (Redirect_Valid) begin
            pc <= redir_pc;
        end else if (hs) begin
            pc     <= pc_plus4;
            req_pc <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Inst_Valid <= 1'b0;
            Inst       <= 32'd0;
            Inst_PC    <= 32'd0;
            skid_full  <= 1'b0;
            skid_inst  <= 32'd0;
            skid_pc    <= 32'd0;
        end else if (Redirect_Valid) begin
            Inst_Valid <= 1'b0;
            skid_full  <= 1'b0;
        end else if (skid_full && consume) begin
            Inst      <= skid_inst;
            Inst_PC   <= skid_pc;
            skid_full <= 1'b0;
        end else if (resp && out_free) begin
            Inst       <= IMem_RData;
            Inst_PC    <= req_pc;
            Inst_Valid <= 1'b1;
        end else if (resp) begin
            skid_inst <= IMem_RData;
            skid_pc   <= req_pc;
            skid_full <= 1'b1;
        end else if (consume) begin
            Inst_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch against a queue-based fetch stream model.
// Honours PC_ALIGN_CHECK_EN when the design is built with it.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall;
    logic        Redirect_Valid;
    logic [31:0] Redirect_PC;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ready;
    logic        IMem_RValid;
    logic [31:0] IMem_RData;
    logic        Inst_Valid;
    logic [31:0] Inst;
    logic [31:0] Inst_PC;
    logic [31:0] PC_Result;
`ifdef PC_ALIGN_CHECK_EN
    logic        Fetch_Misalign;
`endif

    pc_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Stall          (Stall),
        .Redirect_Valid (Redirect_Valid),
        .Redirect_PC    (Redirect_PC),
        .IMem_Req       (IMem_Req),
        .IMem_Addr      (IMem_Addr),
        .IMem_Ready     (IMem_Ready),
        .IMem_RValid    (IMem_RValid),
        .IMem_RData     (IMem_RData),
        .Inst_Valid     (Inst_Valid),
        .Inst           (Inst),
        .Inst_PC        (Inst_PC),
`ifdef PC_ALIGN_CHECK_EN
        .Fetch_Misalign (Fetch_Misalign),
`endif
        .PC_Result      (PC_Result)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: instructions owed to IF/ID in order, next fetch PC,
    // and the single outstanding memory transaction.
    logic [31:0] dq[$];
    logic [31:0] model_pc;
    bit          misal;
    bit          discard;
    bit          mem_busy;
    logic [31:0] mem_pc;
    int          mem_due;
    int          lat_min;
    int          lat_max;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h20080001;
        return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h0F0F_0000;
    endfunction

    task automatic step(input bit stl, input bit rdv,
                        input logic [31:0] rpc, input bit rdy);
        bit  rv;
        bit  hs;
        bit  busy_pre;
        bit  exp_req;
        Stall          = stl;
        Redirect_Valid = rdv;
        Redirect_PC    = rpc;
        IMem_Ready     = rdy;
        rv             = mem_busy && (cyc >= mem_due);
        IMem_RValid    = rv;
        IMem_RData     = rv ? mem_word(mem_pc) : $urandom;
        @(negedge clk);
        exp_req = !mem_busy && (dq.size() < 2)
                  && !(dq.size() != 0 && stl) && !misal;
        chk("req", IMem_Req, exp_req);
        chk("addr", IMem_Addr, model_pc);
        chk("pc_result", PC_Result, model_pc);
        chk("inst_valid", Inst_Valid, dq.size() != 0);
        if (dq.size() != 0) begin
            chk("inst_pc", Inst_PC, dq[0]);
            chk("inst", Inst, mem_word(dq[0]));
        end
`ifdef PC_ALIGN_CHECK_EN
        chk("misalign", Fetch_Misalign, misal);
`endif
        hs = IMem_Req && IMem_Ready;
        if (hs) chk("one_outstanding", mem_busy, 0);
        busy_pre = mem_busy;
        if (rv) mem_busy = 0;
        if (rdv) begin
            dq.delete();
            discard = hs || (busy_pre && !rv);
`ifdef PC_ALIGN_CHECK_EN
            model_pc = rpc;
            misal    = |rpc[1:0];
`else
            model_pc = rpc & ~32'd3;
`endif
        end else begin
            if (dq.size() != 0 && !stl) void'(dq.pop_front());
            if (rv) begin
                if (discard) discard = 0;
                else dq.push_back(mem_pc);
            end
        end
        if (hs) begin
            mem_busy = 1;
            mem_pc   = model_pc;
            mem_due  = cyc + $urandom_range(lat_min, lat_max);
            if (!rdv) model_pc = model_pc + 32'd4;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        dq.delete();
        model_pc = 32'h0;
        misal    = 0;
        discard  = 0;
        mem_busy = 0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        Redirect_Valid = 1'b0;
        IMem_RValid    = 1'b0;
        #1;
        chk("rst_req", IMem_Req, 0);
        chk("rst_valid", Inst_Valid, 0);
        chk("rst_pc", PC_Result, 32'h0);
        chk("rst_inst", Inst, 32'h0);
        chk("rst_inst_pc", Inst_PC, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input bit need_rv);
        int n = 0;
        while (!(mem_busy && (!need_rv || cyc >= mem_due)) && n < 20) begin
            step(0, 0, 32'h0, 1);
            n++;
        end
        chk("wait_budget", mem_busy, 1);
    endtask

    initial begin
        logic [31:0] t;
        int n;
        rst_n          = 1'b0;
        Stall          = 1'b0;
        Redirect_Valid = 1'b0;
        Redirect_PC    = 32'h0;
        IMem_Ready     = 1'b0;
        IMem_RValid    = 1'b0;
        IMem_RData     = 32'h0;
        lat_min        = 1;
        lat_max        = 1;
        model_reset();
        #12;
        chk("rst_req", IMem_Req, 0);
        chk("rst_valid", Inst_Valid, 0);
        chk("rst_pc", PC_Result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        repeat (10) step(0, 0, 32'h0, 1);

        n = 0;
        while (dq.size() == 0 && n < 20) begin
            step(0, 0, 32'h0, 1);
            n++;
        end
        chk("stall_setup", dq.size() != 0, 1);
        repeat (6) step(1, 0, 32'h0, 1);
        repeat (6) step(0, 0, 32'h0, 1);

        lat_min = 3;
        lat_max = 3;
        run_until(0);
        step(0, 0, 32'h0, 1);
        step(0, 1, 32'h0040_0100, 1);
        repeat (12) step(0, 0, 32'h0, 1);

        lat_min = 2;
        lat_max = 2;
        run_until(1);
        step(0, 1, 32'h0040_0200, 1);
        repeat (8) step(0, 0, 32'h0, 1);

        lat_min = 1;
        lat_max = 1;
        step(0, 1, 32'hFFFF_FFF8, 1);
        repeat (10) step(0, 0, 32'h0, 1);

        step(0, 1, 32'h0000_0102, 1);
        repeat (4) step(0, 0, 32'h0, 1);
        step(0, 1, 32'h0000_0100, 1);
        repeat (8) step(0, 0, 32'h0, 1);

        lat_min = 1;
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            t = $urandom;
            t = (t & 32'h0000_0FFC) | 32'h0040_0000;
            if ($urandom_range(0, 7) == 0) t[1:0] = 2'b10;
            step($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3, t,
                 $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
